// File: rtl/clock_phase_gen_pkg.sv
// Shared defaults and field types for the divided-clock phase generator.
// Latency: n/a (types only). Backpressure: n/a.
// Holds the default field width and reset divide code used by the top.
package clock_phase_gen_pkg;

    localparam int CNT_W_DEF   = 8;
    localparam int DEF_DIV_DEF = 1;

    typedef logic [CNT_W_DEF-1:0] half_per_t;
    typedef logic [CNT_W_DEF-1:0] phase_t;

endpackage

// File: rtl/clock_phase_chan.sv
// One divided-clock channel: counter, shadow divide code, registered clk/tick.
// Latency: 1 cycle from a config/sync edge to the registered outputs.
// Backpressure: none; every write and sync pulse is taken in its cycle.
module clock_phase_chan
    import clock_phase_gen_pkg::*;
#(
    parameter int   CNT_W   = CNT_W_DEF,
    parameter int   DEF_DIV = DEF_DIV_DEF,
    parameter logic DEF_EN  = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  logic [CNT_W-1:0] wr_phase,
    input  logic             wr_en,
    input  logic             sync,
    output logic             clk_out,
    output logic             tick,
    output logic             cfg_pend
);

    logic [CNT_W-1:0] act;
    logic [CNT_W-1:0] pnd;
    logic [CNT_W-1:0] phase;
    logic [CNT_W-1:0] cnt;
    logic             en;

    logic [CNT_W-1:0] pnd_nxt;
    logic [CNT_W-1:0] phase_nxt;
    logic [CNT_W-1:0] start_nxt;
    logic             en_nxt;

    // Write lands first so a same-cycle sync or enable sees the new code/phase.
    always_comb begin
        pnd_nxt   = wr ? wr_div   : pnd;
        phase_nxt = wr ? wr_phase : phase;
        en_nxt    = wr ? wr_en    : en;
        start_nxt = (phase_nxt > pnd_nxt) ? pnd_nxt : phase_nxt;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            act     <= CNT_W'(DEF_DIV);
            pnd     <= CNT_W'(DEF_DIV);
            phase   <= '0;
            cnt     <= '0;
            en      <= DEF_EN;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            pnd   <= pnd_nxt;
            phase <= phase_nxt;
            en    <= en_nxt;
            tick  <= 1'b0;
            if (!en_nxt) begin
                act     <= pnd_nxt;
                cnt     <= '0;
                clk_out <= 1'b0;
            end else if (!en || sync) begin
                act     <= pnd_nxt;
                cnt     <= start_nxt;
                clk_out <= 1'b0;
            end else if (cnt == act) begin
                cnt     <= '0;
                clk_out <= ~clk_out;
                tick    <= ~clk_out;
                // New code only at the falling edge so each period stays symmetric.
                if (clk_out) begin
                    act <= pnd_nxt;
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign cfg_pend = en & (pnd != act);

endmodule

// File: rtl/clock_phase_gen.sv
// Bank of NUM_CH independently divided, phase-offsettable 50% clocks.
// Latency: 1 cycle from write/sync to registered clk_out/tick.
// Backpressure: none; writes and sync pulses are always accepted.
module clock_phase_gen
    import clock_phase_gen_pkg::*;
#(
    parameter int              NUM_CH  = 4,
    parameter int              CNT_W   = CNT_W_DEF,
    parameter int              DEF_DIV = DEF_DIV_DEF,
    parameter logic [NUM_CH-1:0] DEF_EN = '1,
    localparam int             CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_wren,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_phase,
    input  logic              cfg_en,
    input  logic              sync,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] cfg_pend
);

    logic [NUM_CH-1:0] wr_sel;

    // Indices at or above NUM_CH never match, so such writes fall away.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_sel[i] = cfg_wren && (cfg_ch == CH_W'(i));
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clock_phase_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV),
            .DEF_EN  (DEF_EN[i])
        ) u_chan (
            .clock    (clock),
            .reset    (reset),
            .wr       (wr_sel[i]),
            .wr_div   (cfg_div),
            .wr_phase (cfg_phase),
            .wr_en    (cfg_en),
            .sync     (sync),
            .clk_out  (clk_out[i]),
            .tick     (tick[i]),
            .cfg_pend (cfg_pend[i])
        );
    end

endmodule

// File: tb/tb_clock_phase_gen.sv
// Directed bench for clock_phase_gen with an event-time reference model.
module tb_clock_phase_gen;

    localparam int NCH     = 4;
    localparam int CW      = 8;
    localparam int DEF_DIV = 1;

    logic           clock;
    logic           reset;
    logic           cfg_wren;
    logic [1:0]     cfg_ch;
    logic [CW-1:0]  cfg_div;
    logic [CW-1:0]  cfg_phase;
    logic           cfg_en;
    logic           sync;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] cfg_pend;

    int n_cmp = 0;
    int n_bad = 0;

    clock_phase_gen #(.NUM_CH(NCH), .CNT_W(CW), .DEF_DIV(DEF_DIV)) dut (
        .clock     (clock),
        .reset     (reset),
        .cfg_wren  (cfg_wren),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_phase (cfg_phase),
        .cfg_en    (cfg_en),
        .sync      (sync),
        .clk_out   (clk_out),
        .tick      (tick),
        .cfg_pend  (cfg_pend)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each channel keeps its level and the absolute edge
    // index of its next toggle; a half-period of code A lasts A+1 edges.
    int now = 0;
    int m_a[NCH], m_p[NCH], m_ph[NCH], m_nxt[NCH];
    bit m_en[NCH], m_lvl[NCH], m_tick[NCH];

    always @(posedge clock) begin
        int s;
        bit en_old, wr;
        logic [NCH-1:0] e_clk, e_tick, e_pend;
        now++;
        for (int i = 0; i < NCH; i++) begin
            if (!reset) begin
                m_a[i] = DEF_DIV; m_p[i] = DEF_DIV; m_ph[i] = 0;
                m_en[i] = 1'b1; m_lvl[i] = 1'b0; m_tick[i] = 1'b0;
                m_nxt[i] = now + DEF_DIV + 1;
            end else begin
                en_old = m_en[i];
                wr = cfg_wren && (int'(cfg_ch) == i);
                if (wr) begin
                    m_p[i] = int'(cfg_div);
                    m_ph[i] = int'(cfg_phase);
                    m_en[i] = cfg_en;
                    if (!en_old || !cfg_en) m_a[i] = m_p[i];
                end
                m_tick[i] = 1'b0;
                if (!m_en[i]) begin
                    m_lvl[i] = 1'b0;
                end else if (!en_old || sync) begin
                    m_a[i] = m_p[i];
                    s = (m_ph[i] < m_a[i]) ? m_ph[i] : m_a[i];
                    m_lvl[i] = 1'b0;
                    m_nxt[i] = now + m_a[i] - s + 1;
                end else if (now == m_nxt[i]) begin
                    m_lvl[i] = !m_lvl[i];
                    m_tick[i] = m_lvl[i];
                    if (!m_lvl[i]) m_a[i] = m_p[i];
                    m_nxt[i] = now + m_a[i] + 1;
                end
            end
        end
        #1;
        for (int i = 0; i < NCH; i++) begin
            e_clk[i]  = m_lvl[i];
            e_tick[i] = m_tick[i];
            e_pend[i] = m_en[i] && (m_p[i] != m_a[i]);
        end
        check("model_clk_out", 32'(clk_out), 32'(e_clk));
        check("model_tick", 32'(tick), 32'(e_tick));
        check("model_cfg_pend", 32'(cfg_pend), 32'(e_pend));
    end

    task automatic do_wr(input int ch, input int dv, input int ph, input bit en, input bit sy);
        cfg_wren  = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_div   = CW'(dv);
        cfg_phase = CW'(ph);
        cfg_en    = en;
        sync      = sy;
        @(negedge clock);
        cfg_wren = 1'b0;
        sync     = 1'b0;
    endtask

    logic [3:0] sync_tbl [4] = '{4'b0001, 4'b0010, 4'b0101, 4'b1000};

    initial begin
        reset = 1'b1;
        cfg_wren = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_phase = '0; cfg_en = 1'b0; sync = 1'b0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_clk_out", 32'(clk_out), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_cfg_pend", 32'(cfg_pend), 32'h0);

        // Defaults: divide-by-4, all channels aligned.
        reset = 1'b1;
        @(negedge clock); check("def_e1_clk", 32'(clk_out), 32'h0);
        @(negedge clock); check("def_e2_clk", 32'(clk_out), 32'hF);
        check("def_e2_tick", 32'(tick), 32'hF);
        @(negedge clock); check("def_e3_clk", 32'(clk_out), 32'hF);
        check("def_e3_tick", 32'(tick), 32'h0);
        @(negedge clock); check("def_e4_clk", 32'(clk_out), 32'h0);
        repeat (2) @(negedge clock);
        check("def_e6_tick", 32'(tick), 32'hF);

        // Divide change during the high half takes effect at the fall.
        do_wr(1, 4, 0, 1'b1, 1'b0);
        check("div_pend_set", 32'(cfg_pend), 32'h2);
        check("div_old_high", 32'(clk_out[1]), 32'h1);
        @(negedge clock);
        check("div_pend_clr", 32'(cfg_pend), 32'h0);
        check("div_fall", 32'(clk_out[1]), 32'h0);
        repeat (5) @(negedge clock);
        check("div_rise_tick", 32'(tick[1]), 32'h1);
        repeat (5) @(negedge clock);
        check("div_fall2", 32'(clk_out[1]), 32'h0);
        repeat (5) @(negedge clock);
        check("div_rise2_tick", 32'(tick[1]), 32'h1);

        // Disable then re-enable with phase offset.
        do_wr(2, 1, 0, 1'b0, 1'b0);
        check("dis_clk", 32'(clk_out[2]), 32'h0);
        check("dis_pend", 32'(cfg_pend[2]), 32'h0);
        repeat (3) @(negedge clock);
        check("dis_hold", 32'(clk_out[2]), 32'h0);
        do_wr(2, 1, 1, 1'b1, 1'b0);
        check("ena_clk", 32'(clk_out[2]), 32'h0);
        @(negedge clock);
        check("ena_rise", 32'(clk_out[2]), 32'h1);
        check("ena_tick", 32'(tick[2]), 32'h1);

        // Phase beyond the code is clamped.
        do_wr(3, 1, 0, 1'b0, 1'b0);
        do_wr(3, 3, 9, 1'b1, 1'b0);
        check("clamp_clk", 32'(clk_out[3]), 32'h0);
        @(negedge clock);
        check("clamp_rise", 32'(clk_out[3]), 32'h1);
        check("clamp_tick", 32'(tick[3]), 32'h1);

        // Codes 0..3 then sync; last write to ch0 wins, ch3 write shares the sync cycle.
        do_wr(0, 5, 0, 1'b1, 1'b0);
        do_wr(0, 0, 0, 1'b1, 1'b0);
        do_wr(1, 1, 0, 1'b1, 1'b0);
        do_wr(2, 2, 0, 1'b1, 1'b0);
        do_wr(3, 3, 0, 1'b1, 1'b1);
        check("sync_clk", 32'(clk_out), 32'h0);
        check("sync_tick", 32'(tick), 32'h0);
        for (int k = 1; k <= 28; k++) begin
            @(negedge clock);
            if (k <= 4) check("sync_tick_seq", 32'(tick), 32'(sync_tbl[k-1]));
            if (k >= 25) check("sync_tick_rep", 32'(tick), 32'(sync_tbl[k-25]));
        end

        // Reset mid-period alongside a write and a sync.
        cfg_wren = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd7; cfg_phase = 8'd3; cfg_en = 1'b1;
        sync = 1'b1;
        reset = 1'b0;
        #1;
        check("arst_clk", 32'(clk_out), 32'h0);
        check("arst_tick", 32'(tick), 32'h0);
        check("arst_pend", 32'(cfg_pend), 32'h0);
        @(negedge clock);
        cfg_wren = 1'b0; sync = 1'b0;
        reset = 1'b1;
        @(negedge clock); check("rel_e1_clk", 32'(clk_out), 32'h0);
        @(negedge clock); check("rel_e2_clk", 32'(clk_out), 32'hF);
        repeat (4) @(negedge clock);
        check("rel_e6_tick", 32'(tick), 32'hF);
        check("rel_pend", 32'(cfg_pend), 32'h0);
        repeat (8) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clock_phase_gen.md
CLOCK_PHASE_GEN -- requirements
Module: clock_phase_gen

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent divided-clock channels (1..16).
REQ-002 Parameter CNT_W, default 8, width of half-period and phase fields.
REQ-003 Parameter DEF_DIV, default 1, reset half-period code (H = DEF_DIV+1, so period 4 cycles).
REQ-004 Parameter DEF_EN, default all ones (NUM_CH bits), reset channel-enable mask.
REQ-005 clock  input  1  sole clock; all state samples on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 cfg_wren  input  1  config write strobe, one cycle per write.
REQ-008 cfg_ch  input  $clog2(NUM_CH) (min 1)  target channel of write; out-of-range index is ignored.
REQ-009 cfg_div  input  CNT_W  half-period code; half-period H = cfg_div+1 cycles.
REQ-010 cfg_phase  input  CNT_W  start counter offset applied on enable/sync.
REQ-011 cfg_en  input  1  channel enable written with the config.
REQ-012 sync  input  1  one-cycle pulse; realigns all enabled channels.
REQ-013 clk_out  output  NUM_CH  registered divided clocks, 50% duty.
REQ-014 tick  output  NUM_CH  registered one-cycle pulse in the cycle clk_out[i] goes 0->1.
REQ-015 cfg_pend  output  NUM_CH  high while a written divide code awaits application.

Function
REQ-016 Per channel: active code A, pending code P, counter cnt (CNT_W), enable bit, output bit.
REQ-017 Enabled channel: cnt increments each cycle; at cnt == A, cnt <= 0 and clk_out toggles.
REQ-018 tick[i] is high exactly in the cycles where clk_out[i] is registered 0->1; otherwise low.
REQ-019 Output period = 2*(A+1) cycles; A = 0 gives clock/2; A = 1 reproduces a fixed divide-by-4.
REQ-020 Write to an enabled channel updates P only; A <= P at the next 1->0 toggle, keeping each period symmetric.
REQ-021 cfg_pend[i] = (P != A) for enabled channels; 0 for disabled channels.
REQ-022 Write to a disabled channel loads A and P immediately.
REQ-023 Write with cfg_en=0: channel disables next cycle; cnt <= 0, clk_out <= 0, tick <= 0; held until re-enabled.
REQ-024 Enable transition 0->1: cnt <= min(phase, A), clk_out <= 0; first toggle after A - cnt + 1 cycles.
REQ-025 sync: every enabled channel sets cnt <= min(phase, A), clk_out <= 0, A <= P; the sync cycle's normal toggle is suppressed.
REQ-026 Simultaneous cfg_wren and sync: write applied first; sync uses newly written code/phase for that channel.
REQ-027 Back-to-back writes to one channel before application: last write wins.
REQ-028 Counter compare is equality on CNT_W bits; no wrap beyond A occurs since phase is clamped.

Reset
REQ-029 reset low asynchronously forces: A = P = DEF_DIV, phase = 0, enable = DEF_EN, cnt = 0, clk_out = 0, tick = 0, cfg_pend = 0.
REQ-030 Reset asserted mid-period aborts the period; after release, enabled channels first toggle after DEF_DIV+1 cycles.
REQ-031 Inputs are ignored while reset is low.

Structure
REQ-032 Shared package holds the CNT_W default, DEF_DIV default and the half-period/phase field typedefs.
REQ-033 One sub-module clock_phase_chan (single channel: counter, shadow code, output/tick regs), instantiated NUM_CH times; top holds write decode and sync fan-out.

Verification
REQ-034 Reset release, defaults -> all clk_out period 4, high 2 cycles, ticks every 4 cycles, aligned.
REQ-035 Write ch1 cfg_div=4 mid-high phase -> cfg_pend[1]=1; old period finishes; next period 10 cycles; cfg_pend[1] clears at the 1->0 toggle.
REQ-036 Write ch2 cfg_en=0, then cfg_en=1 cfg_phase=1 (A=1) -> clk_out[2] low while disabled; first rise 1 cycle after enable.
REQ-037 Channels at cfg_div 0,1,2,3, pulse sync -> all clk_out 0 next cycle, and all ticks coincide every 24 cycles.
REQ-038 cfg_phase=9 with cfg_div=3 -> clamped to 3; toggle on first cycle after enable.
REQ-039 Reset pulled low mid-period, with write and sync in same cycle -> outputs 0 immediately; defaults restored, write discarded.
